// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word-addressed data memory with wait-state handshake and error responses
module data_memory_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        memReady,
    output logic        memError,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Word storage; never cleared by reset.
    logic [31:0] mem [DEPTH];

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic                   error_q, error_d;
    logic                   busy_q, busy_d;

    logic                   req_present;
    logic                   take;
    logic [31:0]            hi_bits;
    logic                   cap_err;
    logic [ADDR_BITS-1:0]   cap_idx;
    logic                   err_eff;
    logic                   write_eff;
    logic [ADDR_BITS-1:0]   idx_eff;
    logic [31:0]            wdata_eff;
    logic                   commit;
    logic                   commit_wr;
    logic                   commit_rd;

    // Request decode and error classification at the capture edge.
    always_comb begin
        req_present = MemRead | MemWrite;
        take        = (state_q == S_IDLE) && req_present;
        hi_bits     = dAddress >> (ADDR_BITS + 2);
        cap_err     = (MemRead & MemWrite) || (dAddress[1:0] != 2'b00) || (hi_bits != 32'd0);
        cap_idx     = dAddress[ADDR_BITS+1:2];
    end

    // With zero wait states the commit happens on the capture edge itself, so
    // the live inputs are used in place of the (not yet loaded) capture registers.
    always_comb begin
        err_eff   = take ? cap_err    : err_q;
        write_eff = take ? MemWrite   : write_q;
        idx_eff   = take ? cap_idx    : idx_q;
        wdata_eff = take ? dWriteData : wdata_q;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: error requests skip WAIT; WAIT counts down to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_present) begin
                    if (cap_err || (WAIT_STATES == 0)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request capture registers, loaded only when IDLE accepts a request.
    always_comb begin
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        if (take) begin
            idx_d   = cap_idx;
            wdata_d = dWriteData;
            write_d = MemWrite;
            err_d   = cap_err;
        end
    end

    // Capture register flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    // Output logic: access commits on the edge entering RESP; outputs are registered.
    always_comb begin
        commit    = (state_d == S_RESP) && (state_q != S_RESP) && !err_eff;
        commit_wr = commit && write_eff;
        commit_rd = commit && !write_eff;
        rdata_d   = commit_rd ? mem[idx_eff] : rdata_q;
        ready_d   = (state_d == S_RESP);
        error_d   = (state_d == S_RESP) && err_eff;
        busy_d    = (state_d != S_IDLE);
    end

    // Output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    // Array write; blocked while reset is held so an interrupted store is dropped.
    always_ff @(posedge clk) begin
        if (commit_wr && !rst) begin
            mem[idx_eff] <= wdata_eff;
        end
    end

    assign dReadData = rdata_q;
    assign memReady  = ready_q;
    assign memError  = error_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench for data_memory_responder
module tb_data_memory_responder;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] a0, d0, a1, d1;
    logic [31:0] q0, q1;
    logic        rdy0, er0, bz0, rdy1, er1, bz1;

    int          pass_cnt;
    int          total_cnt;
    exp_t        sb[$];
    logic [31:0] model0 [logic [31:0]];
    logic [31:0] model1 [logic [31:0]];
    logic [31:0] last0, last1;

    data_memory_responder #(.ADDR_BITS(10), .WAIT_STATES(2)) dut0 (
        .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0),
        .dAddress(a0), .dWriteData(d0), .dReadData(q0),
        .memReady(rdy0), .memError(er0), .busy(bz0)
    );

    data_memory_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst(rst), .MemRead(rd1), .MemWrite(wr1),
        .dAddress(a1), .dWriteData(d1), .dReadData(q1),
        .memReady(rdy1), .memError(er1), .busy(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit sel, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            rd1 = rd; wr1 = wr; a1 = a; d1 = d;
        end else begin
            rd0 = rd; wr0 = wr; a0 = a; d0 = d;
        end
    endtask

    task automatic sample(input bit sel, output logic r, output logic e, output logic b, output logic [31:0] q);
        if (sel) begin
            r = rdy1; e = er1; b = bz1; q = q1;
        end else begin
            r = rdy0; e = er0; b = bz0; q = q0;
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else pass_cnt++;
    endtask

    // One request: expectation pushed at drive time, popped when memReady is seen.
    task automatic run_req(input bit sel, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input string nm);
        exp_t        e;
        exp_t        got_e;
        int          lat;
        bit          seen;
        logic        err;
        logic        r_rdy, r_err, r_busy;
        logic [31:0] r_q;
        err = (rd & wr) | (a[1:0] != 2'b00) | ((a >> 12) != 32'd0);
        if (!err && wr) begin
            if (sel) model1[a] = d; else model0[a] = d;
        end
        if (!err && rd) begin
            if (sel) last1 = model1[a]; else last0 = model0[a];
        end
        e.err  = err;
        e.data = sel ? last1 : last0;
        e.lat  = err ? 1 : (sel ? 1 : 3);
        sb.push_back(e);
        @(negedge clk);
        drive(sel, rd, wr, a, d);
        @(posedge clk);
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) drive(sel, 1'b0, 1'b0, 32'hFFFF_FFF3, ~d);
            sample(sel, r_rdy, r_err, r_busy, r_q);
            total_cnt++;
            if (r_busy !== 1'b1) $display("FAIL %s busy_during: got %b expected 1", nm, r_busy);
            else pass_cnt++;
            if (r_rdy === 1'b1) begin
                seen = 1;
                lat  = i;
                break;
            end
            total_cnt++;
            if (r_err !== 1'b0) $display("FAIL %s error_without_ready: got %b expected 0", nm, r_err);
            else pass_cnt++;
        end
        got_e = sb.pop_front();
        if (!seen) begin
            total_cnt++;
            $display("FAIL %s timeout: got no memReady expected one within 20 cycles", nm);
        end else begin
            total_cnt++;
            if (r_err !== got_e.err) $display("FAIL %s memError: got %b expected %b", nm, r_err, got_e.err);
            else pass_cnt++;
            check32({nm, " dReadData"}, r_q, got_e.data);
            total_cnt++;
            if (lat != got_e.lat) $display("FAIL %s latency: got %0d expected %0d", nm, lat, got_e.lat);
            else pass_cnt++;
        end
        @(negedge clk);
        sample(sel, r_rdy, r_err, r_busy, r_q);
        total_cnt++;
        if ({r_rdy, r_err, r_busy} !== 3'b000)
            $display("FAIL %s after_pulse rdy/err/busy: got %b expected 000", nm, {r_rdy, r_err, r_busy});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        last0 = 32'd0;
        last1 = 32'd0;
        @(negedge clk);
        check32("reset dReadData", q0, 32'd0);
        check32("reset rdy/err/busy", {29'd0, rdy0, er0, bz0}, 32'd0);
        check32("reset dut1 outputs", {29'd0, rdy1, er1, bz1} | q1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        run_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "t1 write 0x10");
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, "t1 read 0x10");
        check32("t1 read value", q0, 32'hDEADBEEF);
    endtask

    task automatic test_errors();
        run_req(0, 1'b0, 1'b1, 32'h0, 32'h00000A0A, "t2 write 0x0");
        run_req(0, 1'b1, 1'b0, 32'h13, 32'h0, "t2 misaligned read");
        check32("t2 dReadData held", q0, 32'hDEADBEEF);
        run_req(0, 1'b0, 1'b1, 32'h1000, 32'h55555555, "t2 out of range write");
        run_req(0, 1'b1, 1'b0, 32'h0, 32'h0, "t2 read 0x0");
        check32("t2 read 0x0 unchanged", q0, 32'h00000A0A);
        run_req(0, 1'b0, 1'b1, 32'hFFC, 32'h0BADF00D, "t2 write top word");
        run_req(0, 1'b1, 1'b0, 32'hFFC, 32'h0, "t2 read top word");
        check32("t2 top word", q0, 32'h0BADF00D);
    endtask

    task automatic test_conflict();
        run_req(0, 1'b1, 1'b1, 32'h10, 32'h12345678, "t3 both strobes");
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, "t3 read 0x10");
        check32("t3 0x10 untouched", q0, 32'hDEADBEEF);
    endtask

    task automatic test_async_reset();
        run_req(0, 1'b0, 1'b1, 32'h20, 32'h11111111, "t4 preload 0x20");
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, "t4 read 0x10");
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 rst = 1'b1;
        #1;
        check32("t4 async reset dReadData", q0, 32'd0);
        check32("t4 async reset rdy/err/busy", {29'd0, rdy0, er0, bz0}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        last0 = 32'd0;
        last1 = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (rdy0 !== 1'b0) $display("FAIL t4 aborted response: got memReady %b expected 0", rdy0);
            else pass_cnt++;
        end
        run_req(0, 1'b1, 1'b0, 32'h20, 32'h0, "t4 read 0x20");
        check32("t4 0x20 not overwritten", q0, 32'h11111111);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   t;
        int   first;
        int   second;
        int   extra;
        run_req(0, 1'b0, 1'b1, 32'h4, 32'h0000B0B0, "t5 write 0x4");
        e.err = 1'b0; e.data = model0[32'h0]; e.lat = 3;
        sb.push_back(e);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        t = 0; first = -1; second = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            t++;
            if (rdy0 === 1'b1) begin
                e = sb.pop_front();
                check32("t5 read data", q0, e.data);
                total_cnt++;
                if (er0 !== e.err) $display("FAIL t5 memError: got %b expected %b", er0, e.err);
                else pass_cnt++;
                if (first < 0) begin
                    first = t;
                    a0    = 32'h4;
                    e.err = 1'b0; e.data = model0[32'h4]; e.lat = 4;
                    sb.push_back(e);
                end else begin
                    second = t;
                    rd0    = 1'b0;
                    break;
                end
            end
        end
        total_cnt++;
        if (first != 3) $display("FAIL t5 first latency: got %0d expected 3", first);
        else pass_cnt++;
        total_cnt++;
        if (second - first != 4) $display("FAIL t5 pulse spacing: got %0d expected 4", second - first);
        else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rdy0 === 1'b1) extra++;
        end
        total_cnt++;
        if (extra != 0) $display("FAIL t5 extra pulses: got %0d expected 0", extra);
        else pass_cnt++;
        total_cnt++;
        if (sb.size() != 0) $display("FAIL t5 scoreboard residue: got %0d expected 0", sb.size());
        else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_zero_wait();
        run_req(1, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, "t6 write 0x8");
        run_req(1, 1'b1, 1'b0, 32'h8, 32'h0, "t6 read 0x8");
        check32("t6 read value", q1, 32'hA5A5A5A5);
        run_req(1, 1'b1, 1'b0, 32'h9, 32'h0, "t6 misaligned");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_write_read();
        test_errors();
        test_conflict();
        test_async_reset();
        test_back_to_back();
        test_zero_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
